biu_arbiter: RTL



---
 rtl/biu_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/biu_arbiter.sv
// Read-port arbiter sharing one memory read channel between the BIUs.
// BIU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority over round-robin.
module biu_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUTS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        biu_req,
  input  logic [NUM_REQ-1:0]        biu_vld,
  input  logic [NUM_REQ*ADDR_W-1:0] biu_addr,
  output logic [NUM_REQ-1:0]        biu_rdy,
  output logic [DATA_W-1:0]         biu_rsp_data,
  output logic [NUM_REQ-1:0]        biu_rsp_vld,
  input  logic [NUM_REQ-1:0]        biu_rsp_rdy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_vld,
  input  logic                      mem_rdy,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  input  logic                      mem_rsp_vld,
  output logic                      mem_rsp_rdy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      rsp_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OW = $clog2(MAX_OUTS) + 1;
  localparam logic [OW-1:0] OUTS_MAX = OW'(MAX_OUTS);
  localparam logic [OW-1:0] OUTS_ONE = OW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IW-1:0]      own;
  logic [IW-1:0]      own_nxt;
  logic [OW-1:0]      outs;
  logic [IW-1:0]      win;
  logic               own_req;
  logic               own_vld;
  logic               own_rrdy;
  logic [ADDR_W-1:0]  own_addr;
  logic               full;
  logic               req_hs;
  logic               rsp_hs;

`ifndef BIU_ARB_FIXED_PRIO_EN
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      rr_nxt;
  logic               found;
  int                 rr_j;
`endif

  assign full   = (outs == OUTS_MAX);
  assign req_hs = mem_vld & mem_rdy;
  assign rsp_hs = mem_rsp_vld & mem_rsp_rdy & (outs != '0);
  assign busy   = (state != IDLE);

  // Pick the next owner among the requesters.
  always_comb begin
    win = '0;
`ifdef BIU_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (biu_req[i]) win = IW'(i);
    end
`else
    found = 1'b0;
    rr_j  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_j = int'(rr_ptr) + k;
      if (rr_j >= NUM_REQ) rr_j = rr_j - NUM_REQ;
      if (!found && biu_req[rr_j]) begin
        win   = IW'(rr_j);
        found = 1'b1;
      end
    end
`endif
  end

  // Select the current owner's channel signals.
  always_comb begin
    own_req  = biu_req[own];
    own_vld  = biu_vld[own];
    own_rrdy = biu_rsp_rdy[own];
    own_addr = biu_addr[int'(own)*ADDR_W +: ADDR_W];
  end

  // Forward owner requests and route responses; all quiet in reset.
  always_comb begin
    mem_vld      = 1'b0;
    mem_addr     = '0;
    biu_rdy      = '0;
    biu_rsp_vld  = '0;
    biu_rsp_data = '0;
    mem_rsp_rdy  = 1'b0;
    if (rst_n) begin
      biu_rsp_data = mem_rsp_data;
      if (state == GRANT) begin
        mem_addr     = own_addr;
        mem_vld      = own_vld & own_req & ~full;
        biu_rdy[own] = mem_rdy & own_req & ~full;
      end
      if (outs == '0) begin
        mem_rsp_rdy = 1'b1;
      end else begin
        biu_rsp_vld[own] = mem_rsp_vld;
        mem_rsp_rdy      = own_rrdy;
      end
    end
  end

  // Next-state logic for ownership.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    own_nxt   = own;
`ifndef BIU_ARB_FIXED_PRIO_EN
    rr_nxt    = rr_ptr;
`endif
    unique case (state)
      IDLE: begin
        if (|biu_req) begin
          state_nxt = GRANT;
          own_nxt   = win;
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_nxt[i] = (win == IW'(i));
          end
        end
      end
      GRANT: begin
        if (!own_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (outs == '0 || (outs == OUTS_ONE && rsp_hs)) begin
          state_nxt = IDLE;
          grant_nxt = '0;
`ifndef BIU_ARB_FIXED_PRIO_EN
          if (int'(own) == NUM_REQ - 1) rr_nxt = '0;
          else rr_nxt = own + IW'(1);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State, ownership, outstanding count and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      own     <= '0;
      outs    <= '0;
      rsp_err <= 1'b0;
`ifndef BIU_ARB_FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      own   <= own_nxt;
`ifndef BIU_ARB_FIXED_PRIO_EN
      rr_ptr <= rr_nxt;
`endif
      if (req_hs && !rsp_hs) outs <= outs + OUTS_ONE;
      else if (rsp_hs && !req_hs) outs <= outs - OUTS_ONE;
      if (mem_rsp_vld && outs == '0) rsp_err <= 1'b1;
    end
  end

endmodule
